// File: rtl/disp_feeder.sv
// disp_feeder: sits in front of the 8-digit seven-segment scanner.
// It makes the scanner's scan clock, selects one of four 32-bit debug sources
// and can freeze the displayed word. Two debounced push buttons drive it.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   src0..src3        32-bit debug sources
//   btn_next          raw button: step to the next source
//   btn_freeze        raw button: toggle freeze of the display word
//   clk_1K            50% duty scan clock, DISP_HZ
//   F                 display word (registered, 1-cycle latency from sel)
//   sel               selected source index
//   frozen            1 = F is held
module disp_feeder #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned DISP_HZ   = 1000,
    parameter int unsigned DEB_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] src3,
    input  logic        btn_next,
    input  logic        btn_freeze,
    output logic        clk_1K,
    output logic [31:0] F,
    output logic [1:0]  sel,
    output logic        frozen
);

    localparam int unsigned HALF  = CLK_HZ / (2 * DISP_HZ);
    localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned DEB_W = $clog2(DEB_TICKS + 1);
    localparam int unsigned NBTN  = 2;

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             tick;

    logic [NBTN-1:0]  btn_raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  acc;
    logic [NBTN-1:0]  acc_d;
    logic [DEB_W-1:0] deb_cnt [NBTN];

    logic             next_p;
    logic             frz_p;
    logic             load_pending;
    logic [31:0]      src_mux;

    // Scan clock divider; tick marks the wrap that drives clk_1K low.
    assign div_wrap = (div_cnt == DIV_W'(HALF - 1));
    assign tick     = div_wrap && clk_1K;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            clk_1K  <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            clk_1K  <= ~clk_1K;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Button synchronizers and debouncers; index 0 = next, 1 = freeze.
    assign btn_raw = {btn_freeze, btn_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_d <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            acc_d <= acc;
            if (tick) begin
                for (int i = 0; i < int'(NBTN); i++) begin
                    if (sync2[i] != acc[i]) begin
                        // Accept on the tick that would bring the count to DEB_TICKS.
                        if (deb_cnt[i] == DEB_W'(DEB_TICKS - 1)) begin
                            acc[i]     <= sync2[i];
                            deb_cnt[i] <= '0;
                        end else begin
                            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // One-cycle press pulses on accepted 0->1 transitions only.
    assign next_p = acc[0] & ~acc_d[0];
    assign frz_p  = acc[1] & ~acc_d[1];

    // Source multiplexer driven by the registered select.
    always_comb begin
        src_mux = src0;
        case (sel)
            2'd0:    src_mux = src0;
            2'd1:    src_mux = src1;
            2'd2:    src_mux = src2;
            2'd3:    src_mux = src3;
            default: src_mux = src0;
        endcase
    end

    // Select, freeze state and display word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel          <= 2'd0;
            frozen       <= 1'b0;
            load_pending <= 1'b0;
            F            <= '0;
        end else begin
            if (next_p) begin
                sel <= sel + 2'd1;
            end
            if (frz_p) begin
                frozen <= ~frozen;
            end
            // A step while frozen (or freezing) grabs one snapshot of the new source.
            load_pending <= next_p & (frozen ^ frz_p);
            if (!frozen || load_pending) begin
                F <= src_mux;
            end
        end
    end

endmodule
